// File: rtl/cpu_out_port.sv
// Output-port stage behind the cpu core: one latched register per port plus a
// show-ahead FIFO of write events drained by a valid/ready sink.
module cpu_out_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [(2**ADDR_W)*DATA_W-1:0]    port_q,
    output logic                             out_valid,
    output logic [ADDR_W-1:0]                out_addr,
    output logic [DATA_W-1:0]                out_data,
    input  logic                             out_ready,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
    input  logic                             clr_ovf
);

    localparam int NPORT = 2**ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A write into a full FIFO still lands when the head leaves in the same cycle.
    assign push      = wr_en && (!full || pop);

    assign {out_addr, out_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                if (wr_en && (wr_addr == ADDR_W'(k))) begin
                    port_q[k*DATA_W +: DATA_W] <= wr_data;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // A fresh drop takes priority over a clear request.
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_addr, wr_data};
        end
    end

endmodule

// File: tb/tb_cpu_out_port.sv
// Self-checking bench for cpu_out_port: directed vector table, hand sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_cpu_out_port;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int NP    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NP*DW-1:0]    port_q;
    logic                out_valid;
    logic [AW-1:0]       out_addr;
    logic [DW-1:0]       out_data;
    logic                out_ready;
    logic                full;
    logic                empty;
    logic [2:0]          count;
    logic                overflow;
    logic                clr_ovf;

    int total = 0;
    int bad   = 0;

    cpu_out_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .port_q(port_q), .out_valid(out_valid),
        .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: a queue of {addr,data} entries, port array, sticky flag.
    logic [AW+DW-1:0] mq[$];
    logic [DW-1:0]    mports [NP];
    logic             movf;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rdy;
        logic          clr;
        int            ecount;
        logic          evalid;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        logic          eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rst, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic rdy, input logic clr,
                          input int ecount, input logic evalid, input logic [AW-1:0] eaddr,
                          input logic [DW-1:0] edata, input logic eovf);
        vec_t v;
        v.rst = rst; v.we = we; v.a = a; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ecount = ecount; v.evalid = evalid; v.eaddr = eaddr; v.edata = edata; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NP*DW-1:0] modelPorts();
        logic [NP*DW-1:0] p;
        for (int k = 0; k < NP; k++) p[k*DW +: DW] = mports[k];
        return p;
    endfunction

    // Advance the model by one clock edge using the pre-edge state.
    task automatic modelStep(input logic rst, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic mpop;
        logic mfull;
        if (!rst) begin
            mq.delete();
            for (int k = 0; k < NP; k++) mports[k] = '0;
            movf = 1'b0;
        end else begin
            mpop  = (mq.size() > 0) && rdy;
            mfull = (mq.size() == DEPTH);
            if (we) mports[a] = d;
            if (we && mfull && !mpop) movf = 1'b1;
            else if (clr) movf = 1'b0;
            if (mpop) void'(mq.pop_front());
            if (we && (!mfull || mpop)) mq.push_back({a, d});
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        reset = rst; wr_en = we; wr_addr = a; wr_data = d; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        modelStep(rst, we, a, d, rdy, clr);
        #1;
    endtask

    task automatic checkOutput();
        cmp("count", 64'(count), 64'(mq.size()));
        cmp("empty", 64'(empty), 64'(mq.size() == 0));
        cmp("full", 64'(full), 64'(mq.size() == DEPTH));
        cmp("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        cmp("overflow", 64'(overflow), 64'(movf));
        cmp("port_q", 64'(port_q), 64'(modelPorts()));
        if (mq.size() != 0) begin
            cmp("head", 64'({out_addr, out_data}), 64'(mq[0]));
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        for (int k = 0; k < NP; k++) mports[k] = '0;
        movf = 1'b0;

        // rst we a d rdy clr | count valid addr data ovf
        addVec(0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0);
        addVec(0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0);
        addVec(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
        addVec(1, 1, 2, 8'h5A, 0, 0, 1, 1, 2, 8'h5A, 0);
        addVec(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        addVec(1, 1, 1, 8'h01, 0, 0, 1, 1, 1, 8'h01, 0);
        addVec(1, 1, 1, 8'h02, 0, 0, 2, 1, 1, 8'h01, 0);
        addVec(1, 1, 1, 8'h03, 0, 0, 3, 1, 1, 8'h01, 0);
        addVec(1, 1, 1, 8'h04, 0, 0, 4, 1, 1, 8'h01, 0);
        addVec(1, 1, 1, 8'h05, 0, 0, 4, 1, 1, 8'h01, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 3, 1, 1, 8'h02, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 2, 1, 1, 8'h03, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h04, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1);
        addVec(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            cmp($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ecount));
            cmp($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].evalid));
            cmp($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].eovf));
            if (vecs[i].evalid) begin
                cmp($sformatf("vec%0d_head", i), 64'({out_addr, out_data}),
                    64'({vecs[i].eaddr, vecs[i].edata}));
            end
            checkOutput();
        end
        cmp("port1_after_fill", 64'(port_q[1*DW +: DW]), 64'h05);
        cmp("port2_after_single", 64'(port_q[2*DW +: DW]), 64'h5A);

        // Simultaneous push/pop at full must neither drop nor flag overflow.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 8'h10 + 8'(i), 0, 0);
            checkOutput();
        end
        applyStimulus(1, 1, 3, 8'h14, 1, 0);
        checkOutput();
        cmp("fullpp_count", 64'(count), 64'd4);
        cmp("fullpp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("fullpp_drain%0d", i), 64'(out_data), 64'h11 + 64'(i));
            applyStimulus(1, 0, 0, 8'h00, 1, 0);
            checkOutput();
        end
        cmp("fullpp_empty", 64'(empty), 64'd1);

        // Push and pop together with a single entry keeps count at 1.
        applyStimulus(1, 1, 1, 8'h31, 0, 0);
        applyStimulus(1, 1, 2, 8'h32, 1, 0);
        checkOutput();
        cmp("onepp_count", 64'(count), 64'd1);
        cmp("onepp_head", 64'({out_addr, out_data}), 64'({2'd2, 8'h32}));
        applyStimulus(1, 0, 0, 8'h00, 1, 0);
        checkOutput();

        // Alternate write and drain across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 2'(i % 4), 8'h20 + 8'(i), 0, 0);
            checkOutput();
            cmp($sformatf("wrap%0d_head", i), 64'({out_addr, out_data}),
                64'({2'(i % 4), 8'h20 + 8'(i)}));
            cmp($sformatf("wrap%0d_count", i), 64'(count), 64'd1);
            applyStimulus(1, 0, 0, 8'h00, 1, 0);
            checkOutput();
        end

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2'(i), 8'h40 + 8'(i), 0, 0);
        cmp("mid_count_pre", 64'(count), 64'd3);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput();
        cmp("mid_count", 64'(count), 64'd0);
        cmp("mid_valid", 64'(out_valid), 64'd0);
        cmp("mid_port_q", 64'(port_q), 64'd0);
        applyStimulus(1, 1, 3, 8'h77, 0, 0);
        checkOutput();
        cmp("mid_fresh_head", 64'({out_addr, out_data}), 64'({2'd3, 8'h77}));
        cmp("mid_fresh_count", 64'(count), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom), 2'($urandom),
                          8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
